// File: rtl/smi_req_type_router.sv
// Routes SMI request frames to a read or write port by the header type byte; unknown types are dropped.
// Optional macro SMI_REQ_ROUTER_DROP_COUNT_EN enables the saturating discarded-frame counter on dropCount.
module smi_req_type_router #(
   parameter int unsigned DataIndexSize = 4,
   parameter int unsigned DataWidth     = (1 << DataIndexSize) * 8,
   parameter logic [7:0]  ReadReqId     = 8'h01,
   parameter logic [7:0]  WriteReqId    = 8'h02
) (
   input  logic                 clk,
   input  logic                 arstn,
   input  logic                 smiInReady,
   input  logic [7:0]           smiInEofc,
   input  logic [DataWidth-1:0] smiInData,
   output logic                 smiInStop,
   output logic                 smiRdReady,
   output logic [7:0]           smiRdEofc,
   output logic [DataWidth-1:0] smiRdData,
   input  logic                 smiRdStop,
   output logic                 smiWrReady,
   output logic [7:0]           smiWrEofc,
   output logic [DataWidth-1:0] smiWrData,
   input  logic                 smiWrStop,
   output logic [15:0]          dropCount
);

   localparam int unsigned EofcWidth  = 8;
   localparam int unsigned CountWidth = 16;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      ROUTE_READ  = 2'd1,
      ROUTE_WRITE = 2'd2,
      DISCARD     = 2'd3
   } state_t;

   logic [1:0]           rst_sync_q;
   logic                 rst_n;
   state_t               state_q, state_d;
   logic                 in_valid_q;
   logic [EofcWidth-1:0] in_eofc_q;
   logic [DataWidth-1:0] in_data_q;
   logic                 sel_rd_c, sel_wr_c, sel_drop_c;
   logic                 rd_free_c, wr_free_c;
   logic                 last_c, move_c, in_accept_c;
   logic                 rd_load_c, wr_load_c;

   // Assert asynchronously, release two clocks after arstn rises
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Destination of the registered flit, its movement, and the next frame state
   always_comb begin
      state_d    = state_q;
      sel_rd_c   = 1'b0;
      sel_wr_c   = 1'b0;
      sel_drop_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_data_q[7:0] == ReadReqId)       sel_rd_c   = 1'b1;
            else if (in_data_q[7:0] == WriteReqId) sel_wr_c   = 1'b1;
            else                                   sel_drop_c = 1'b1;
         end
         ROUTE_READ:  sel_rd_c   = 1'b1;
         ROUTE_WRITE: sel_wr_c   = 1'b1;
         DISCARD:     sel_drop_c = 1'b1;
      endcase
      rd_free_c = !smiRdReady || !smiRdStop;
      wr_free_c = !smiWrReady || !smiWrStop;
      last_c    = (in_eofc_q != '0);
      move_c    = in_valid_q && (sel_drop_c || (sel_rd_c && rd_free_c) || (sel_wr_c && wr_free_c));
      rd_load_c = move_c && sel_rd_c;
      wr_load_c = move_c && sel_wr_c;
      if (move_c) begin
         if (last_c)                state_d = IDLE;
         else if (state_q == IDLE)  state_d = sel_rd_c ? ROUTE_READ :
                                              (sel_wr_c ? ROUTE_WRITE : DISCARD);
      end
   end

   assign smiInStop   = in_valid_q && !move_c;
   assign in_accept_c = smiInReady && !smiInStop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           in_valid_q <= 1'b0;
      else if (in_accept_c) in_valid_q <= 1'b1;
      else if (move_c)      in_valid_q <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (in_accept_c) begin
         in_eofc_q <= smiInEofc;
         in_data_q <= smiInData;
      end
   end

   // Output slots: Ready holds until the flit is taken, payload only reloads on a new flit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smiRdReady <= 1'b0;
         smiWrReady <= 1'b0;
      end else begin
         if (rd_load_c)       smiRdReady <= 1'b1;
         else if (!smiRdStop) smiRdReady <= 1'b0;
         if (wr_load_c)       smiWrReady <= 1'b1;
         else if (!smiWrStop) smiWrReady <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_load_c) begin
         smiRdEofc <= in_eofc_q;
         smiRdData <= in_data_q;
      end
      if (wr_load_c) begin
         smiWrEofc <= in_eofc_q;
         smiWrData <= in_data_q;
      end
   end

`ifdef SMI_REQ_ROUTER_DROP_COUNT_EN
   logic drop_frame_c;
   assign drop_frame_c = move_c && sel_drop_c && last_c;

   // One count per discarded frame, taken on its final flit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dropCount <= '0;
      else if (drop_frame_c && (dropCount != {CountWidth{1'b1}}))
         dropCount <= dropCount + CountWidth'(1);
   end
`else
   assign dropCount = '0;
`endif

endmodule
